// File: rtl/comparator_sar_search_pkg.sv
// rtl/comparator_sar_search_pkg.sv - shared state encoding and helpers for the SAR comparator search
package comparator_sar_search_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // IDLE and SEARCH encodings are shared by the controller and anything that
    // observes its state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } sar_state_t;

    // Comparator flags packed as {gt, lt, eq}; exactly one must be set.
    function automatic logic flags_legal(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

endpackage

// File: rtl/comparator_sar_search.sv
// rtl/comparator_sar_search.sv - MSB-first binary search driving an external magnitude comparator
module comparator_sar_search
    import comparator_sar_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

    sar_state_t       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [2:0]       flags;
    logic [WIDTH-1:0] step;
    logic             finish;
    logic [WIDTH-1:0] fin_value;
    logic             fin_err;

    assign flags = {a_gt_b, a_lt_b, a_eq_b};

    // Register all controller state; reset aborts any search without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            trial_q  <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: one comparator evaluation per cycle while searching.
    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        idx_d     = idx_q;
        result_d  = result_q;
        err_d     = err_q;
        done_d    = 1'b0;
        step      = trial_q;
        finish    = 1'b0;
        fin_value = trial_q;
        fin_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                trial_d = '0;
                if (start) begin
                    state_d = ST_SEARCH;
                    trial_d = MSB_ONLY;
                    idx_d   = MSB_IDX;
                    err_d   = 1'b0;
                end
            end

            ST_SEARCH: begin
                if (!flags_legal(flags)) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (a_eq_b) begin
                    finish = 1'b1;
                end else begin
                    // Target below trial: the bit under test must be dropped.
                    if (a_lt_b) begin
                        step[idx_q] = 1'b0;
                    end
                    if (idx_q == '0) begin
                        // Still above trial after the LSB means no value fits.
                        finish    = 1'b1;
                        fin_value = step;
                        fin_err   = a_gt_b;
                    end else begin
                        step[idx_q - 1'b1] = 1'b1;
                        trial_d = step;
                        idx_d   = idx_q - 1'b1;
                    end
                end

                if (finish) begin
                    state_d  = ST_IDLE;
                    trial_d  = '0;
                    idx_d    = '0;
                    done_d   = 1'b1;
                    result_d = fin_value;
                    err_d    = fin_err;
                end
            end

            default: begin
                state_d = ST_IDLE;
                trial_d = '0;
            end
        endcase
    end

    assign trial  = trial_q;
    assign busy   = (state_q == ST_SEARCH);
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule
